// File: rtl/ddr_word_unpacker.sv
// Serialises 128-bit DDR read-FIFO words into a narrow LSB-first pixel AXIS stream.
// One word is buffered, and a word can be loaded in the same cycle its last pixel leaves.
module ddr_word_unpacker #(
   parameter int unsigned PIXEL_WIDTH    = 16,
   parameter int unsigned UNDERRUN_WIDTH = 16
) (
   input  logic                      receiver_clk,
   input  logic                      receiver_rstn,
   input  logic                      receiver_axis_tvalid,
   output logic                      receiver_axis_tready,
   input  logic [127:0]              receiver_axis_tdata,
   input  logic                      receiver_axis_tuser,
   output logic                      pixel_axis_tvalid,
   input  logic                      pixel_axis_tready,
   output logic [PIXEL_WIDTH-1:0]    pixel_axis_tdata,
   output logic                      pixel_axis_tuser,
   output logic [UNDERRUN_WIDTH-1:0] underrun_count
);

   localparam int unsigned WORD_WIDTH      = 128;
   localparam int unsigned PIXELS_PER_WORD = WORD_WIDTH / PIXEL_WIDTH;
   localparam int unsigned IDX_WIDTH       = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PIXELS_PER_WORD - 1);

   if ((WORD_WIDTH % PIXEL_WIDTH) != 0) begin : g_bad_pixel_width
      $error("ddr_word_unpacker: PIXEL_WIDTH must divide 128");
   end

   logic [PIXELS_PER_WORD-1:0][PIXEL_WIDTH-1:0] word_buf;
   logic                 buf_user;
   logic                 buf_valid;
   logic [IDX_WIDTH-1:0] idx;
   logic                 armed;

   logic in_fire;
   logic px_fire;
   logic is_last;
   logic starved;

   assign is_last = (idx == LAST_IDX);
   assign px_fire = buf_valid & pixel_axis_tready;
   assign in_fire = receiver_axis_tvalid & receiver_axis_tready;
   assign starved = armed & pixel_axis_tready & ~buf_valid;

   // Ready is combinational from pixel_axis_tready so reload costs no bubble
   assign receiver_axis_tready = receiver_rstn & (~buf_valid | (px_fire & is_last));

   assign pixel_axis_tvalid = buf_valid;
   assign pixel_axis_tdata  = word_buf[idx];
   assign pixel_axis_tuser  = buf_user & (idx == '0);

   always_ff @(posedge receiver_clk or negedge receiver_rstn) begin
      if (!receiver_rstn) begin
         word_buf       <= '0;
         buf_user       <= 1'b0;
         buf_valid      <= 1'b0;
         idx            <= '0;
         armed          <= 1'b0;
         underrun_count <= '0;
      end else begin
         if (in_fire) begin
            word_buf  <= receiver_axis_tdata;
            buf_user  <= receiver_axis_tuser;
            buf_valid <= 1'b1;
            idx       <= '0;
            armed     <= 1'b1;
         end else if (px_fire) begin
            if (is_last) begin
               buf_valid <= 1'b0;
               idx       <= '0;
            end else begin
               idx <= idx + IDX_WIDTH'(1);
            end
         end
         // Saturating starvation counter; idle before the first word is not counted
         if (starved && !(&underrun_count)) begin
            underrun_count <= underrun_count + UNDERRUN_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_ddr_word_unpacker.sv
// Randomised and directed bench for ddr_word_unpacker against a queue-based pixel model.
module tb_ddr_word_unpacker;

   localparam int unsigned PW  = 16;
   localparam int unsigned UW  = 16;
   localparam int unsigned PPW = 128 / PW;

   typedef struct {
      logic [PW-1:0] d;
      logic          u;
   } pix_t;

   typedef struct {
      logic [127:0] d;
      logic         u;
   } word_t;

   logic          clk;
   logic          rstn;
   logic          rx_tvalid;
   logic          rx_tready;
   logic [127:0]  rx_tdata;
   logic          rx_tuser;
   logic          px_tvalid;
   logic          px_tready;
   logic [PW-1:0] px_tdata;
   logic          px_tuser;
   logic [UW-1:0] underrun;

   ddr_word_unpacker #(.PIXEL_WIDTH(PW), .UNDERRUN_WIDTH(UW)) dut (
      .receiver_clk        (clk),
      .receiver_rstn       (rstn),
      .receiver_axis_tvalid(rx_tvalid),
      .receiver_axis_tready(rx_tready),
      .receiver_axis_tdata (rx_tdata),
      .receiver_axis_tuser (rx_tuser),
      .pixel_axis_tvalid   (px_tvalid),
      .pixel_axis_tready   (px_tready),
      .pixel_axis_tdata    (px_tdata),
      .pixel_axis_tuser    (px_tuser),
      .underrun_count      (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_err = 0;
   pix_t  pq[$];
   word_t src[$];
   bit    armed = 0;
   int    starve_cnt = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at posedge+1, check at posedge+4, advance model at the next posedge
   task automatic step(input logic pr, input logic en);
      logic          fv;
      logic          exp_valid, exp_ready, in_fire, px_fire;
      logic [PW-1:0] exp_data;
      logic          exp_user;
      int            exp_cnt;
      fv = en && (src.size() > 0);
      rx_tvalid = fv;
      rx_tdata  = fv ? src[0].d : '0;
      rx_tuser  = fv ? src[0].u : 1'b0;
      px_tready = pr;
      #3;
      if (!rstn) begin
         exp_valid = 1'b0;
         exp_ready = 1'b0;
         exp_data  = '0;
         exp_user  = 1'b0;
         exp_cnt   = 0;
      end else begin
         exp_valid = (pq.size() > 0);
         exp_ready = (pq.size() == 0) || (pq.size() == 1 && pr);
         exp_data  = exp_valid ? pq[0].d : '0;
         exp_user  = exp_valid ? pq[0].u : 1'b0;
         exp_cnt   = (starve_cnt > 65535) ? 65535 : starve_cnt;
      end
      check("pixel_tvalid", 128'(px_tvalid), 128'(exp_valid));
      check("receiver_tready", 128'(rx_tready), 128'(exp_ready));
      check("underrun_count", 128'(underrun), 128'(exp_cnt));
      if (exp_valid || !rstn) begin
         check("pixel_tdata", 128'(px_tdata), 128'(exp_data));
         check("pixel_tuser", 128'(px_tuser), 128'(exp_user));
      end
      @(posedge clk);
      if (!rstn) begin
         pq.delete();
         armed = 0;
         starve_cnt = 0;
      end else begin
         in_fire = fv && exp_ready;
         px_fire = exp_valid && pr;
         if (armed && pr && !exp_valid) starve_cnt++;
         if (px_fire) void'(pq.pop_front());
         if (in_fire) begin
            word_t w;
            w = src.pop_front();
            for (int k = 0; k < int'(PPW); k++) begin
               pix_t p;
               p.d = PW'(w.d >> (k * PW));
               p.u = w.u && (k == 0);
               pq.push_back(p);
            end
            armed = 1;
         end
      end
      #1;
   endtask

   function automatic word_t rand_word();
      word_t w;
      w.d = {$urandom, $urandom, $urandom, $urandom};
      w.u = ($urandom_range(0, 3) == 0);
      return w;
   endfunction

   initial begin
      word_t w;
      logic  pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      rstn = 1'b0;
      rx_tvalid = 1'b0;
      rx_tdata  = '0;
      rx_tuser  = 1'b0;
      px_tready = 1'b0;
      @(posedge clk);
      #1;

      // Reset held with a word offered, then release and single-frame-start word
      w.d = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
      w.u = 1'b1;
      src.push_back(w);
      repeat (3) step(1'b1, 1'b1);
      rstn = 1'b1;
      step(1'b1, 1'b1);
      check("first_word_accepted", 128'(src.size()), 128'(0));
      for (int k = 0; k < 8; k++) begin
         check("known_pixel", 128'(px_tdata), 128'(k));
         step(1'b1, 1'b1);
      end

      // Two back-to-back words, no gap
      src.push_back(rand_word());
      src.push_back(rand_word());
      repeat (18) step(1'b1, 1'b1);

      // Stall pattern 1,0,0,1 with a second word waiting
      src.push_back(rand_word());
      src.push_back(rand_word());
      for (int i = 0; i < 48; i++) step(pat[i % 4], 1'b1);

      // Drain, then exactly five starved cycles
      repeat (20) step(1'b1, 1'b1);
      w.d = 128'h1;
      w.u = 1'b0;
      src.push_back(w);
      step(1'b1, 1'b1);
      repeat (8) step(1'b1, 1'b0);
      repeat (5) step(1'b1, 1'b0);
      check("underrun_after_5", 128'(underrun), 128'(starve_cnt));

      // Saturation
      for (int i = 0; i < 65540; i++) step(1'b1, 1'b0);
      check("underrun_saturated", 128'(underrun), 128'(16'hFFFF));

      // Reset mid-word at idx 3
      src.push_back(rand_word());
      step(1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      rstn = 1'b0;
      repeat (2) step(1'b1, 1'b0);
      rstn = 1'b1;
      w.d = 128'h00FF_00EE_00DD_00CC_00BB_00AA_0099_0088;
      w.u = 1'b1;
      src.push_back(w);
      step(1'b1, 1'b1);
      check("post_reset_pixel0", 128'(px_tdata), 128'(16'h0088));
      check("post_reset_underrun", 128'(underrun), 128'(0));
      repeat (8) step(1'b1, 1'b1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (src.size() < 2 && $urandom_range(0, 2) == 0) src.push_back(rand_word());
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
